// File: rtl/pattern_line_unpacker_pkg.sv
// Constants and types shared by the pattern line unpacker and its matching compressor.
// Both sides must agree on the select codes and the header layout.
package pattern_line_unpacker_pkg;

    localparam int NUM_PATTERNS          = 8;
    localparam int NUM_FIRST_TRANSFORMER = 2;
    localparam int NUM_LAST_TRANSFORMER  = 6;
    localparam int WORD_WIDTH            = 32;
    localparam int NUM_WORDS             = 16;

    // The header length field and the word counter share this width.
    localparam int LEN_W = 5;

    localparam int SEL_ALL_ZERO = 0;
    localparam int SEL_ALL_SAME = 1;
    localparam int SEL_UNCOMP   = NUM_PATTERNS - 1;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_line_unpacker_header_decode.sv
// Combinational header decode: select code, number of payload words to collect,
// whether the line can be emitted without payload, and whether the header is malformed.
module pattern_header_decode
    import pattern_line_unpacker_pkg::*;
#(
    parameter int NUM_PATTERNS          = pattern_line_unpacker_pkg::NUM_PATTERNS,
    parameter int NUM_FIRST_TRANSFORMER = pattern_line_unpacker_pkg::NUM_FIRST_TRANSFORMER,
    parameter int NUM_LAST_TRANSFORMER  = pattern_line_unpacker_pkg::NUM_LAST_TRANSFORMER,
    parameter int WORD_WIDTH            = pattern_line_unpacker_pkg::WORD_WIDTH,
    parameter int NUM_WORDS             = pattern_line_unpacker_pkg::NUM_WORDS
) (
    input  logic [WORD_WIDTH-1:0]           hdr_i,
    output logic [$clog2(NUM_PATTERNS)-1:0] select_o,
    output logic [LEN_W-1:0]                exp_len_o,
    output logic                            direct_emit_o,
    output logic                            err_o
);

    localparam int SW = $clog2(NUM_PATTERNS);

    localparam logic [SW-1:0]    CODE_ZERO   = SW'(SEL_ALL_ZERO);
    localparam logic [SW-1:0]    CODE_SAME   = SW'(SEL_ALL_SAME);
    localparam logic [SW-1:0]    CODE_UNCOMP = SW'(SEL_UNCOMP);
    localparam logic [SW-1:0]    CODE_FIRST  = SW'(NUM_FIRST_TRANSFORMER);
    localparam logic [SW-1:0]    CODE_LAST   = SW'(NUM_LAST_TRANSFORMER);
    localparam logic [LEN_W-1:0] FULL_LEN    = LEN_W'(NUM_WORDS);

    logic [SW-1:0]    sel;
    logic [LEN_W-1:0] len_field;
    logic             unused_hdr_bits;

    assign sel             = hdr_i[WORD_WIDTH-1 -: SW];
    assign len_field       = hdr_i[LEN_W-1:0];
    assign unused_hdr_bits = ^hdr_i[WORD_WIDTH-SW-1:LEN_W];

    always_comb begin
        // NOTE: every output gets a default before the branches so no path leaves one unassigned, which would infer a latch.
        select_o      = sel;
        exp_len_o     = '0;
        direct_emit_o = 1'b0;
        err_o         = 1'b0;

        if (sel == CODE_ZERO) begin
            direct_emit_o = 1'b1;
        end else if (sel == CODE_SAME) begin
            exp_len_o = LEN_W'(1);
        end else if (sel == CODE_UNCOMP) begin
            exp_len_o = FULL_LEN;
        end else if (sel >= CODE_FIRST && sel <= CODE_LAST) begin
            if (len_field == '0) begin
                direct_emit_o = 1'b1;
                err_o         = 1'b1;
            end else if (len_field > FULL_LEN) begin
                exp_len_o = FULL_LEN;
                err_o     = 1'b1;
            end else begin
                exp_len_o = len_field;
            end
        end else begin
            // Codes outside every defined class: emit an empty error line.
            direct_emit_o = 1'b1;
            err_o         = 1'b1;
        end
    end

endmodule

// File: rtl/pattern_line_unpacker.sv
// Rebuilds a full cache line from a header beat plus zero or more payload beats,
// then holds the line on a valid/ready output until it is consumed.
module pattern_line_unpacker
    import pattern_line_unpacker_pkg::*;
#(
    parameter int NUM_PATTERNS          = pattern_line_unpacker_pkg::NUM_PATTERNS,
    parameter int NUM_FIRST_TRANSFORMER = pattern_line_unpacker_pkg::NUM_FIRST_TRANSFORMER,
    parameter int NUM_LAST_TRANSFORMER  = pattern_line_unpacker_pkg::NUM_LAST_TRANSFORMER,
    parameter int WORD_WIDTH            = pattern_line_unpacker_pkg::WORD_WIDTH,
    parameter int NUM_WORDS             = pattern_line_unpacker_pkg::NUM_WORDS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    input  logic [WORD_WIDTH-1:0]           in_data_i,
    output logic                            in_ready_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [$clog2(NUM_PATTERNS)-1:0] out_select_o,
    output logic [WORD_WIDTH*NUM_WORDS-1:0] out_data_o,
    output logic [4:0]                      out_len_o,
    output logic                            err_o
);

    localparam int SW = $clog2(NUM_PATTERNS);

    // Index NUM_WORDS-1 is the most significant word, so slot k lives at [NUM_WORDS-1-k].
    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] line_t;

    state_e           state_q,     state_d;
    logic [LEN_W-1:0] cnt_q,       cnt_d;
    logic [LEN_W-1:0] exp_len_q,   exp_len_d;
    logic [LEN_W-1:0] out_len_q,   out_len_d;
    logic [SW-1:0]    select_q,    select_d;
    logic             err_q,       err_d;
    logic             all_same_q,  all_same_d;
    logic             out_valid_q, out_valid_d;
    line_t            line_q,      line_d;

    logic [SW-1:0]    dec_select;
    logic [LEN_W-1:0] dec_exp_len;
    logic             dec_direct;
    logic             dec_err;

    pattern_header_decode #(
        .NUM_PATTERNS          (NUM_PATTERNS),
        .NUM_FIRST_TRANSFORMER (NUM_FIRST_TRANSFORMER),
        .NUM_LAST_TRANSFORMER  (NUM_LAST_TRANSFORMER),
        .WORD_WIDTH            (WORD_WIDTH),
        .NUM_WORDS             (NUM_WORDS)
    ) u_header_decode (
        .hdr_i         (in_data_i),
        .select_o      (dec_select),
        .exp_len_o     (dec_exp_len),
        .direct_emit_o (dec_direct),
        .err_o         (dec_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_len_d   = exp_len_q;
        out_len_d   = out_len_q;
        select_d    = select_q;
        err_d       = err_q;
        all_same_d  = all_same_q;
        out_valid_d = out_valid_q;
        line_d      = line_q;

        unique case (state_q)
            ST_HDR: begin
                if (in_valid_i) begin
                    select_d   = dec_select;
                    err_d      = dec_err;
                    exp_len_d  = dec_exp_len;
                    all_same_d = (dec_select == SW'(SEL_ALL_SAME));
                    cnt_d      = '0;
                    out_len_d  = '0;
                    line_d     = '0;
                    if (dec_direct) begin
                        state_d     = ST_EMIT;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end

            ST_COLLECT: begin
                if (in_valid_i) begin
                    // An all-same line has one payload word that fills every slot.
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        if (all_same_q || cnt_q == LEN_W'(i)) begin
                            line_d[NUM_WORDS-1-i] = in_data_i;
                        end
                    end
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == exp_len_q) begin
                        state_d     = ST_EMIT;
                        out_valid_d = 1'b1;
                        out_len_d   = cnt_d;
                    end
                end
            end

            ST_EMIT: begin
                if (out_ready_i) begin
                    state_d     = ST_HDR;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_HDR;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: non-blocking assignments only, so every flop samples its pre-edge _d value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HDR;
            cnt_q       <= '0;
            exp_len_q   <= '0;
            out_len_q   <= '0;
            select_q    <= '0;
            err_q       <= 1'b0;
            all_same_q  <= 1'b0;
            out_valid_q <= 1'b0;
            // NOTE: the wide line register is reset too, because out_data_o must read as zero after reset.
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_len_q   <= exp_len_d;
            out_len_q   <= out_len_d;
            select_q    <= select_d;
            err_q       <= err_d;
            all_same_q  <= all_same_d;
            out_valid_q <= out_valid_d;
            line_q      <= line_d;
        end
    end

    assign in_ready_o   = (state_q != ST_EMIT);
    assign out_valid_o  = out_valid_q;
    assign out_select_o = select_q;
    assign out_data_o   = line_q;
    assign out_len_o    = out_len_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_pattern_line_unpacker.sv
// Directed bench for pattern_line_unpacker: expected lines go into a scoreboard queue
// and a monitor pops and compares each line at its output handshake.
module tb_pattern_line_unpacker;
    import pattern_line_unpacker_pkg::*;

    localparam int SW = $clog2(NUM_PATTERNS);
    localparam int LW = WORD_WIDTH * NUM_WORDS;

    typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] line_t;

    typedef struct {
        logic [SW-1:0] sel;
        line_t         data;
        logic [4:0]    len;
        logic          err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid_i;
    logic [WORD_WIDTH-1:0] in_data_i;
    logic                  in_ready_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [SW-1:0]         out_select_o;
    logic [LW-1:0]         out_data_o;
    logic [4:0]            out_len_o;
    logic                  err_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pattern_line_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_select_o (out_select_o),
        .out_data_o   (out_data_o),
        .out_len_o    (out_len_o),
        .err_o        (err_o)
    );

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [SW-1:0] sel, input line_t data,
                            input logic [4:0] len, input logic err);
        exp_t e;
        e.sel  = sel;
        e.data = data;
        e.len  = len;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Called one step after a rising edge; returns one step after the accepting edge.
    task automatic send_beat(input logic [WORD_WIDTH-1:0] d);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: beat %h not accepted in %0d cycles", d, t);
        end
    endtask

    // Monitor: compares each presented line at the cycle its handshake completes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_line: got select %0d len %0d, expected no line",
                             out_select_o, out_len_o);
                end else begin
                    e = sb.pop_front();
                    check("line_select", LW'(out_select_o), LW'(e.sel));
                    check("line_len",    LW'(out_len_o),    LW'(e.len));
                    check("line_err",    LW'(err_o),        LW'(e.err));
                    check("line_data",   out_data_o,        e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line_t ln;
        line_t line_a;

        rst         = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b1;

        @(posedge clk);
        @(negedge clk);
        check("rst_valid",  LW'(out_valid_o),  LW'(1'b0));
        check("rst_err",    LW'(err_o),        LW'(1'b0));
        check("rst_select", LW'(out_select_o), LW'(0));
        check("rst_len",    LW'(out_len_o),    LW'(0));
        check("rst_data",   out_data_o,        LW'(0));
        check("rst_ready",  LW'(in_ready_o),   LW'(1'b1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Uncompressed line: words 0..15, length field ignored.
        for (int k = 0; k < NUM_WORDS; k++) ln[NUM_WORDS-1-k] = WORD_WIDTH'(k);
        push_exp(3'd7, ln, 5'd16, 1'b0);
        send_beat(32'hE000_0000);
        for (int k = 0; k < NUM_WORDS; k++) send_beat(WORD_WIDTH'(k));

        // All-zero line: valid in the cycle right after the accepting edge.
        push_exp(3'd0, '0, 5'd0, 1'b0);
        send_beat(32'h0000_0000);
        check("sel0_latency", LW'(out_valid_o), LW'(1'b1));

        // All-word-same line.
        for (int k = 0; k < NUM_WORDS; k++) ln[k] = 32'hDEAD_BEEF;
        push_exp(3'd1, ln, 5'd1, 1'b0);
        send_beat(32'h2000_0000);
        send_beat(32'hDEAD_BEEF);

        // Transformer select 3, length 3, with back-pressure for 5 cycles.
        line_a     = '0;
        line_a[15] = 32'hAAAA_0001;
        line_a[14] = 32'hBBBB_0002;
        line_a[13] = 32'hCCCC_0003;
        push_exp(3'd3, line_a, 5'd3, 1'b0);
        send_beat(32'h6000_0003);
        out_ready_i = 1'b0;
        send_beat(32'hAAAA_0001);
        send_beat(32'hBBBB_0002);
        send_beat(32'hCCCC_0003);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid",  LW'(out_valid_o),  LW'(1'b1));
            check("hold_ready",  LW'(in_ready_o),   LW'(1'b0));
            check("hold_select", LW'(out_select_o), LW'(3));
            check("hold_len",    LW'(out_len_o),    LW'(3));
            check("hold_data",   out_data_o,        line_a);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;

        // Transformer with length 0: empty error line.
        push_exp(3'd4, '0, 5'd0, 1'b1);
        send_beat(32'h8000_0000);

        // Transformer with length 20: clamped to 16 words, error flagged.
        for (int k = 0; k < NUM_WORDS; k++) ln[NUM_WORDS-1-k] = 32'h0000_0100 + WORD_WIDTH'(k);
        push_exp(3'd4, ln, 5'd16, 1'b1);
        send_beat(32'h8000_0014);
        for (int k = 0; k < NUM_WORDS; k++) send_beat(32'h0000_0100 + WORD_WIDTH'(k));

        // Reset after 5 of 16 uncompressed words: the partial line is dropped.
        send_beat(32'hE000_0000);
        for (int k = 0; k < 5; k++) send_beat(32'h0000_5000 + WORD_WIDTH'(k));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", LW'(out_valid_o), LW'(1'b0));
        check("post_rst_ready", LW'(in_ready_o),  LW'(1'b1));
        check("post_rst_data",  out_data_o,       LW'(0));
        @(posedge clk);
        #1;

        // First header after the reset decodes as a header, not as payload.
        ln     = '0;
        ln[15] = 32'h1111_1111;
        ln[14] = 32'h2222_2222;
        push_exp(3'd5, ln, 5'd2, 1'b0);
        send_beat(32'hA000_0002);
        send_beat(32'h1111_1111);
        send_beat(32'h2222_2222);

        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d lines outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
